turn_signal_seq: RTL and testbench



---
 rtl/turn_sig_pkg.sv | 30 +++
 rtl/step_prescaler.sv | 33 +++
 rtl/turn_signal_seq.sv | 130 +++++++++++++
 tb/tb_turn_signal_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/turn_sig_pkg.sv
`default_nettype none
// ============================================================================
// turn_sig_pkg : shared types and request decode for the turn-signal sequencer
// Rev 1.0
// ============================================================================
package turn_sig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } mode_t;

    // Hazard wins, and simultaneous left+right is treated as hazard.
    function automatic mode_t decode(input logic left, input logic right, input logic hazard);
        mode_t m;
        if (hazard | (left & right))
            m = HAZ;
        else if (left)
            m = LEFT;
        else if (right)
            m = RIGHT;
        else
            m = IDLE;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_prescaler.sv
`default_nettype none
// ============================================================================
// step_prescaler : divides clk into one-cycle step pulses every TICK_DIV cycles
// Rev 1.0
// ============================================================================
module step_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam int              CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   c_last = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    assign step = en & (r_count == c_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (en)
            r_count <= step ? '0 : r_count + CW'(1);
    end

endmodule
`default_nettype wire

// File: rtl/turn_signal_seq.sv
`default_nettype none
// ============================================================================
// turn_signal_seq : N-lamp sequential turn-signal / hazard controller
// Rev 1.0
// ============================================================================
module turn_signal_seq
    import turn_sig_pkg::*;
#(
    parameter int N_LAMPS  = 3,
    parameter int TICK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
    input  logic               hazard,
    output logic [N_LAMPS-1:0] lamp_l,
    output logic [N_LAMPS-1:0] lamp_r,
    output logic               busy
);

    localparam int                 IW         = $clog2(N_LAMPS + 1);
    localparam logic [IW-1:0]      c_last_idx = IW'(N_LAMPS);
    localparam logic [N_LAMPS-1:0] c_ones     = '1;

    mode_t              r_mode, w_mode_n, w_req;
    logic [IW-1:0]      r_idx, w_idx_n;
    logic               r_phase, w_phase_n;
    logic [N_LAMPS-1:0] r_lamp_l, r_lamp_r, w_lamp_l_n, w_lamp_r_n, w_therm;
    logic               r_busy;
    logic               w_step;

    step_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (r_mode == IDLE),
        .en    (r_mode != IDLE),
        .step  (w_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode   <= IDLE;
            r_idx    <= '0;
            r_phase  <= 1'b0;
            r_lamp_l <= '0;
            r_lamp_r <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_mode   <= w_mode_n;
            r_idx    <= w_idx_n;
            r_phase  <= w_phase_n;
            r_lamp_l <= w_lamp_l_n;
            r_lamp_r <= w_lamp_r_n;
            r_busy   <= (w_mode_n != IDLE);
        end
    end

    always_comb begin
        w_req      = decode(left, right, hazard);
        w_mode_n   = r_mode;
        w_idx_n    = r_idx;
        w_phase_n  = r_phase;
        w_lamp_l_n = '0;
        w_lamp_r_n = '0;
        w_therm    = '0;

        case (r_mode)
            IDLE: begin
                if (w_req != IDLE) begin
                    w_mode_n  = w_req;
                    w_phase_n = (w_req == HAZ);
                    w_idx_n   = (w_req == HAZ) ? '0 : IW'(1);
                end
            end
            LEFT, RIGHT: begin
                if (w_step) begin
                    if (w_req == HAZ) begin
                        w_mode_n  = HAZ;
                        w_phase_n = 1'b1;
                        w_idx_n   = '0;
                    end else if (r_idx == '0) begin
                        // Decision point: restart in the requested direction or stop.
                        w_mode_n = w_req;
                        w_idx_n  = (w_req == IDLE) ? '0 : IW'(1);
                    end else if (r_idx == c_last_idx) begin
                        w_idx_n = '0;
                    end else begin
                        w_idx_n = r_idx + IW'(1);
                    end
                end
            end
            HAZ: begin
                if (w_step) begin
                    if (r_phase) begin
                        w_phase_n = 1'b0;
                    end else begin
                        w_mode_n  = w_req;
                        w_phase_n = (w_req == HAZ);
                        w_idx_n   = (w_req == LEFT || w_req == RIGHT) ? IW'(1) : '0;
                    end
                end
            end
            default: begin
                w_mode_n = IDLE;
                w_idx_n  = '0;
            end
        endcase

        w_therm = ~(c_ones << w_idx_n);

        case (w_mode_n)
            LEFT:    w_lamp_l_n = w_therm;
            RIGHT:   w_lamp_r_n = w_therm;
            HAZ: begin
                w_lamp_l_n = w_phase_n ? c_ones : '0;
                w_lamp_r_n = w_phase_n ? c_ones : '0;
            end
            default: ;
        endcase
    end

    assign lamp_l = r_lamp_l;
    assign lamp_r = r_lamp_r;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_seq.sv
`default_nettype none
// ============================================================================
// tb_turn_signal_seq : directed plus randomized checks against a sequence model
// Rev 1.0
// ============================================================================
module tb_turn_signal_seq;

    logic       clk;
    logic       reset;
    logic       left, right, hazard;
    logic [2:0] lamp_l_a, lamp_r_a;
    logic [4:0] lamp_l_b, lamp_r_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    // mode: 0 idle, 1 left, 2 right, 3 hazard; pos = lit lamp count
    typedef struct {
        int mode;
        int pos;
        int ph;
        int cnt;
    } model_t;

    model_t ma, mb;

    turn_signal_seq #(.N_LAMPS(3), .TICK_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .lamp_l(lamp_l_a), .lamp_r(lamp_r_a), .busy(busy_a)
    );

    turn_signal_seq #(.N_LAMPS(5), .TICK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .lamp_l(lamp_l_b), .lamp_r(lamp_r_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic model_t m_reset();
        model_t m;
        m.mode = 0; m.pos = 0; m.ph = 0; m.cnt = 0;
        return m;
    endfunction

    function automatic model_t m_start(model_t s, int want);
        model_t m = s;
        m.mode = want;
        m.pos  = (want == 1 || want == 2) ? 1 : 0;
        m.ph   = (want == 3) ? 1 : 0;
        m.cnt  = 0;
        return m;
    endfunction

    // Advance one clock edge given the inputs seen at that edge.
    function automatic model_t m_step(model_t s, int n, int td, bit l, bit r, bit h);
        model_t m = s;
        int     want;
        bit     pulse;
        want = (h || (l && r)) ? 3 : l ? 1 : r ? 2 : 0;
        if (m.mode == 0) begin
            if (want != 0) m = m_start(m, want);
            return m;
        end
        pulse = (m.cnt == td - 1);
        m.cnt = pulse ? 0 : m.cnt + 1;
        if (!pulse) return m;
        if (m.mode == 3) begin
            if (m.ph == 1) m.ph = 0;
            else           m = m_start(m, want);
        end else begin
            if (want == 3)       m = m_start(m, 3);
            else if (m.pos == 0) m = m_start(m, want);
            else                 m.pos = (m.pos == n) ? 0 : m.pos + 1;
        end
        return m;
    endfunction

    function automatic logic [31:0] exp_side(model_t m, int n, int side);
        if (m.mode == side) return 32'((1 << m.pos) - 1);
        if (m.mode == 3 && m.ph == 1) return 32'((1 << n) - 1);
        return 32'd0;
    endfunction

    task automatic compare_all();
        chk("a_lamp_l", 32'(lamp_l_a), exp_side(ma, 3, 1));
        chk("a_lamp_r", 32'(lamp_r_a), exp_side(ma, 3, 2));
        chk("a_busy",   32'(busy_a),   32'(ma.mode != 0));
        chk("b_lamp_l", 32'(lamp_l_b), exp_side(mb, 5, 1));
        chk("b_lamp_r", 32'(lamp_r_b), exp_side(mb, 5, 2));
        chk("b_busy",   32'(busy_b),   32'(mb.mode != 0));
    endtask

    // One clock edge; inputs must be stable before it. Returns at edge + 1.
    task automatic tick();
        if (reset) begin
            ma = m_step(ma, 3, 4, left, right, hazard);
            mb = m_step(mb, 5, 1, left, right, hazard);
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic async_reset_pulse();
        #3 reset = 1'b0;
        ma = m_reset();
        mb = m_reset();
        #1;
        chk("rst_a_lamp_l", 32'(lamp_l_a), 32'd0);
        chk("rst_a_busy",   32'(busy_a),   32'd0);
        compare_all();
        #1 reset = 1'b1;
    endtask

    // Leaves the bench at edge 0 + 1, all inputs low.
    task automatic do_reset();
        left = 1'b0; right = 1'b0; hazard = 1'b0;
        reset = 1'b0;
        ma = m_reset();
        mb = m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_lamp_l", 32'(lamp_l_a), 32'd0);
        chk("reset_a_lamp_r", 32'(lamp_r_a), 32'd0);
        chk("reset_a_busy",   32'(busy_a),   32'd0);
        chk("reset_b_lamp_l", 32'(lamp_l_b), 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        logic [4:0] b_seq [7];
        int         sel, hold;
        b_seq = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000, 5'b00001};

        // Left held: both instances
        do_reset();
        left = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1)  chk("held_l@1",  32'(lamp_l_a), 32'h1);
            if (k == 5)  chk("held_l@5",  32'(lamp_l_a), 32'h3);
            if (k == 9)  chk("held_l@9",  32'(lamp_l_a), 32'h7);
            if (k == 13) chk("held_l@13", 32'(lamp_l_a), 32'h0);
            if (k == 17) chk("held_l@17", 32'(lamp_l_a), 32'h1);
            if (k == 9)  chk("held_r@9",  32'(lamp_r_a), 32'h0);
            if (k == 1)  chk("held_busy@1", 32'(busy_a), 32'h1);
            if (k <= 7)  chk("fast_l", 32'(lamp_l_b), 32'(b_seq[k-1]));
        end

        // Single-cycle left pulse completes its sweep
        do_reset();
        left = 1'b1;
        tick();
        left = 1'b0;
        for (int k = 2; k <= 17; k++) begin
            tick();
            if (k == 9)  chk("pulse_l@9",    32'(lamp_l_a), 32'h7);
            if (k == 16) chk("pulse_busy@16", 32'(busy_a), 32'h1);
            if (k == 17) chk("pulse_busy@17", 32'(busy_a), 32'h0);
        end

        // Left + right together acts as hazard
        do_reset();
        left = 1'b1; right = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) chk("both_r@1", 32'(lamp_r_a), 32'h7);
            if (k == 5) chk("both_l@5", 32'(lamp_l_a), 32'h0);
            if (k == 9) chk("both_l@9", 32'(lamp_l_a), 32'h7);
            if (k == 10) begin left = 1'b0; right = 1'b0; end
            if (k == 13) chk("both_l@13", 32'(lamp_l_a), 32'h0);
            if (k == 17) chk("both_busy@17", 32'(busy_a), 32'h0);
        end

        // Hazard preempts a left sweep mid-way
        do_reset();
        left = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 5)  chk("pre_l@5",  32'(lamp_l_a), 32'h3);
            if (k == 6)  hazard = 1'b1;
            if (k == 9)  chk("pre_r@9",  32'(lamp_r_a), 32'h7);
            if (k == 13) chk("pre_l@13", 32'(lamp_l_a), 32'h0);
            if (k == 14) hazard = 1'b0;
            if (k == 17) chk("pre_l@17", 32'(lamp_l_a), 32'h1);
            if (k == 17) chk("pre_r@17", 32'(lamp_r_a), 32'h0);
        end

        // Side switch at the decision point
        do_reset();
        left = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 13) chk("sw_l@13", 32'(lamp_l_a), 32'h0);
            if (k == 14) begin left = 1'b0; right = 1'b1; end
            if (k == 17) chk("sw_r@17", 32'(lamp_r_a), 32'h1);
            if (k == 21) chk("sw_r@21", 32'(lamp_r_a), 32'h3);
            if (k == 21) chk("sw_l@21", 32'(lamp_l_a), 32'h0);
        end

        // Asynchronous reset mid-sweep, then restart
        do_reset();
        left = 1'b1;
        repeat (7) tick();
        async_reset_pulse();
        tick();
        chk("rst_restart_l", 32'(lamp_l_a), 32'h1);

        // Randomized traffic against the model
        for (int it = 0; it < 600; it++) begin
            sel  = int'($urandom_range(0, 9));
            hold = int'($urandom_range(1, 14));
            left   = (sel == 1 || sel == 2 || sel == 6);
            right  = (sel == 3 || sel == 4 || sel == 6);
            hazard = (sel == 7);
            for (int c = 0; c < hold; c++) begin
                tick();
                if ($urandom_range(0, 199) == 0) async_reset_pulse();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
